// File: rtl/fetch_stage.sv
// fetch_stage: single-outstanding instruction fetch with a one-entry skid
// buffer and branch redirect.
//
// Handshakes (one rule for every interface of this block):
//   - imem: a request is live while imem_req=1; imem_addr does not change
//     until the cycle imem_ack=1, which also carries imem_rdata.
//   - decode: an instruction is offered while valid=1 and is taken on a
//     rising edge where stall=0; while stall=1 and valid=1 every output holds.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   stall              decode cannot accept this cycle
//   br_taken/br_target redirect pulse and its target (low two bits ignored)
//   imem_req/imem_addr instruction-memory request and word address
//   imem_ack/imem_rdata memory response strobe and data
//   valid/instr/pc     live instruction, its word and its address
//   itype/illegal      format code of instr and unknown-opcode flag
//   dbgState           current FSM state (IDLE=0, BUSY=1, SKID=2, KILL=3)
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [2:0]  itype,
  output logic        illegal,
  output logic [1:0]  dbgState
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, SKID = 2'd2, KILL = 2'd3} fetchState_e;

  localparam logic [2:0] TYPE_R = 3'b000;
  localparam logic [2:0] TYPE_I = 3'b001;
  localparam logic [2:0] TYPE_B = 3'b010;
  localparam logic [2:0] TYPE_S = 3'b011;
  localparam logic [2:0] TYPE_U = 3'b100;
  localparam logic [2:0] TYPE_J = 3'b101;

  fetchState_e state, stateNext;
  logic [31:0] fetchPc;
  logic [31:0] reqAddr;
  logic [31:0] skidWord;
  logic [31:0] brTarget;
  logic [31:0] loadWord;
  logic [2:0]  loadType;
  logic        loadIllegal;
  logic        space;
  logic        busyAccept;
  logic        skidAccept;

  // Returns {itype, illegal} for a 32-bit instruction word.
  function automatic logic [3:0] decodeType(input logic [31:0] word);
    logic [3:0] res;
    case (word[6:0])
      7'b0110011:                                  res = {TYPE_R, 1'b0};
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: res = {TYPE_I, 1'b0};
      7'b1100011:                                  res = {TYPE_B, 1'b0};
      7'b0100011:                                  res = {TYPE_S, 1'b0};
      7'b0110111, 7'b0010111:                      res = {TYPE_U, 1'b0};
      7'b1101111:                                  res = {TYPE_J, 1'b0};
      default:                                     res = {TYPE_R, 1'b1};
    endcase
    return res;
  endfunction

  assign brTarget   = br_target & ~32'h3;
  assign space      = !valid || !stall;
  assign busyAccept = (state == BUSY) && imem_ack && !br_taken && space;
  assign skidAccept = (state == SKID) && !br_taken && space;
  assign loadWord   = (state == SKID) ? skidWord : imem_rdata;
  assign {loadType, loadIllegal} = decodeType(loadWord);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (br_taken || space) stateNext = BUSY;
      BUSY: begin
        if (br_taken)                stateNext = imem_ack ? BUSY : KILL;
        else if (imem_ack && !space) stateNext = SKID;
      end
      SKID: if (br_taken || space) stateNext = BUSY;
      // The stale response ends the kill; a redirect arriving in the same
      // cycle simply becomes the address of the new request.
      KILL: if (imem_ack) stateNext = BUSY;
      default: stateNext = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    imem_req  = (state == BUSY) || (state == KILL);
    imem_addr = reqAddr;
    dbgState  = state;
  end

  // Datapath: fetch PC, request address, skid entry and decode outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetchPc  <= RESET_PC;
      reqAddr  <= RESET_PC;
      skidWord <= '0;
      valid    <= 1'b0;
      instr    <= '0;
      pc       <= '0;
      itype    <= TYPE_R;
      illegal  <= 1'b0;
    end else begin
      if (br_taken)                      fetchPc <= brTarget;
      else if (busyAccept || skidAccept) fetchPc <= fetchPc + 32'd4;

      // reqAddr only moves when a new request is about to start, so it is
      // stable for the whole life of an outstanding request.
      case (state)
        IDLE: begin
          if (br_taken)   reqAddr <= brTarget;
          else if (space) reqAddr <= fetchPc;
        end
        BUSY: begin
          if (imem_ack && br_taken) reqAddr <= brTarget;
          else if (busyAccept)      reqAddr <= fetchPc + 32'd4;
        end
        SKID: begin
          if (br_taken)        reqAddr <= brTarget;
          else if (skidAccept) reqAddr <= fetchPc + 32'd4;
        end
        KILL: if (imem_ack) reqAddr <= br_taken ? brTarget : fetchPc;
        default: reqAddr <= reqAddr;
      endcase

      if (br_taken)
        skidWord <= '0;
      else if (state == BUSY && imem_ack && !space)
        skidWord <= imem_rdata;

      if (br_taken) begin
        valid <= 1'b0;
      end else if (busyAccept || skidAccept) begin
        valid   <= 1'b1;
        instr   <= loadWord;
        pc      <= fetchPc;
        itype   <= loadType;
        illegal <= loadIllegal;
      end else if (!stall) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC loaded on reset.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 stall  input  1  decode cannot accept; output registers SHALL hold while valid=1.
REQ-005 br_taken  input  1  single-cycle redirect pulse; SHALL have priority over stall.
REQ-006 br_target  input  32  redirect PC, sampled when br_taken=1.
REQ-007 imem_req  output  1  instruction-memory request.
REQ-008 imem_addr  output  32  request address, word aligned.
REQ-009 imem_ack  input  1  response strobe; imem_rdata valid in the same cycle.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 valid  output  1  instr/pc/itype hold a live instruction.
REQ-012 instr  output  32  registered instruction word, feeding the immediate decoder.
REQ-013 pc  output  32  address of instr.
REQ-014 itype  output  3  format code: R=000, I=001, B=010, S=011, U=100, J=101.
REQ-015 illegal  output  1  opcode not in the REQ-021 table.

Function
REQ-016 SHALL implement states IDLE, BUSY, SKID and KILL; imem_req=1 only in BUSY and KILL.
REQ-017 imem_addr and imem_req SHALL stay stable from the cycle req rises until the cycle ack=1.
REQ-018 space = !valid | !stall; IDLE->BUSY when space=1, loading imem_addr from fetch_pc.
REQ-019 BUSY with ack and space: SHALL load instr, pc, itype and illegal, set valid=1, set fetch_pc+=4 (mod 2^32), and stay BUSY with the next address on the following cycle.
REQ-020 BUSY with ack and no space: SHALL capture rdata into a one-entry skid register and enter SKID; in SKID, when space=1, SHALL move the skid entry to the outputs, set fetch_pc+=4 and enter BUSY.
REQ-021 itype SHALL be decoded from instr[6:0] as follows: 0110011->R; 0010011, 0000011, 1100111, 1110011->I; 1100011->B; 0100011->S; 0110111, 0010111->U; 1101111->J; any other opcode->R with illegal=1.
REQ-022 With stall=0 and no new accept, valid SHALL fall to 0 on the next edge; with stall=1 and valid=1, all outputs SHALL hold.
REQ-023 On br_taken=1: valid SHALL be 0 on the next edge, the skid register SHALL be cleared, and fetch_pc SHALL be loaded with br_target.
REQ-024 br_taken in BUSY without ack: SHALL enter KILL, keeping imem_req and imem_addr unchanged; on ack in KILL, rdata SHALL be discarded and the state SHALL become BUSY with imem_addr=fetch_pc.
REQ-025 br_taken in BUSY coincident with ack: rdata SHALL be discarded and the state SHALL remain BUSY with imem_addr=br_target next cycle.
REQ-026 br_taken in IDLE or SKID SHALL go to BUSY with imem_addr=br_target; br_taken in KILL SHALL stay in KILL and update fetch_pc only.
REQ-027 With zero-wait memory (ack tied to req) and no stall, throughput SHALL be one instruction per cycle with one-cycle latency from req to valid.
REQ-028 br_target[1:0] SHALL be forced to 00.

Reset
REQ-029 When rst=1, on the edge: state=IDLE, fetch_pc=RESET_PC, valid=0, instr=0, pc=0, itype=000, illegal=0, skid cleared, imem_req=0.
REQ-030 rst SHALL override br_taken, stall and ack in the same cycle; an outstanding request SHALL be abandoned and its ack ignored.
REQ-031 The first imem_req SHALL assert in the second cycle after rst falls, with imem_addr=RESET_PC.

Verification
REQ-032 Zero-wait memory returning 0x00500093, 0x00000463, 0x0000006F; no stall -> valid on consecutive cycles, pc 0,4,8, itype 001,010,101.
REQ-033 Stall raised for 3 cycles while BUSY and ack arrives -> SKID entered, outputs frozen, skid word presented on the first unstalled cycle, no instruction lost or duplicated.
REQ-034 br_taken with target 0x100 while ack is delayed 2 cycles -> KILL, stale word discarded, next imem_addr=0x100, valid=0 until the 0x100 word arrives.
REQ-035 br_taken coincident with ack and stall=1 -> response dropped, valid=0 next cycle, imem_addr=br_target.
REQ-036 imem_rdata=0x0000007F -> itype=000, illegal=1; rst asserted mid-BUSY -> all REQ-029 values, ack in the next cycle ignored.
